// File: rtl/data_mem_bus.sv
// Single-port 32-bit data memory behind a valid/ready request/response bus.
// Byte/half/word loads and stores, alignment and range faults, one request in flight.
module data_mem_bus #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    // state    | meaning
    // ST_IDLE  | no response held, next valid request is accepted
    // ST_RSP   | response held on rsp_*, waiting for rsp_ready

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RSP  = 1'b1
    } state_t;

    state_t      state_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem_q [DEPTH] = '{default: '0};

    logic [IDX_W-1:0] word_idx;
    logic             out_of_range;
    logic             misaligned;
    logic             acc_err_d;
    logic [31:0]      rd_word;
    logic [31:0]      rd_shift;
    logic [31:0]      ld_data_d;
    logic [31:0]      rsp_rdata_d;
    logic [3:0]       wr_be_d;
    logic [31:0]      wr_data_d;

    assign word_idx     = req_addr[IDX_W+1:2];
    assign out_of_range = |(req_addr >> (IDX_W + 2));
    assign rd_word      = mem_q[word_idx];

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    assign acc_err_d = misaligned | out_of_range;

    // Load path: move the selected lane(s) down to bit 0, then extend.
    always_comb begin
        rd_shift  = rd_word >> {req_addr[1:0], 3'b000};
        ld_data_d = rd_word;
        case (req_size)
            SZ_BYTE: ld_data_d = req_unsigned ? {24'h000000, rd_shift[7:0]}
                                              : {{24{rd_shift[7]}}, rd_shift[7:0]};
            SZ_HALF: ld_data_d = req_unsigned ? {16'h0000, rd_shift[15:0]}
                                              : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ld_data_d = rd_word;
        endcase
    end

    assign rsp_rdata_d = (acc_err_d || req_we) ? 32'h0 : ld_data_d;

    // Store path: replicate the right-aligned data across lanes and pick lanes by enable.
    always_comb begin
        wr_be_d   = 4'b0000;
        wr_data_d = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                wr_be_d   = 4'b0001 << req_addr[1:0];
                wr_data_d = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                wr_be_d   = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data_d = {2{req_wdata[15:0]}};
            end
            SZ_WORD: begin
                wr_be_d   = 4'b1111;
                wr_data_d = req_wdata;
            end
            default: begin
                wr_be_d   = 4'b0000;
                wr_data_d = req_wdata;
            end
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);

    // Memory contents are deliberately left alone by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_q     <= ST_RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= acc_err_d;
                        if (req_we && !acc_err_d) begin
                            for (int b = 0; b < 4; b++) begin
                                if (wr_be_d[b]) begin
                                    mem_q[word_idx][8*b +: 8] <= wr_data_d[8*b +: 8];
                                end
                            end
                        end
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    rsp_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_bus.sv
// Directed bench for data_mem_bus: loads/stores, faults, back-pressure and reset.
module tb_data_mem_bus;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total;
    int bad;

    logic [31:0] rd;
    logic        er;

    data_mem_bus #(.DEPTH(256), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    // One full transaction, entered and left 1 time unit after a posedge.
    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic err);
        drive(we, sz, uns, addr, wd);
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rsp_valid_after_accept", {31'h0, rsp_valid}, 32'h1);
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_after_retire", {31'h0, rsp_valid}, 32'h0);
    endtask

    task automatic op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
        xact(we, sz, uns, addr, wd, rd, er);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, {31'h0, er}, {31'h0, exp_err});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        #2;
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        op("init_lw40",   1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
        op("sw10",        1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        op("lw10",        1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        op("sb11",        1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA80, 32'h0, 1'b0);
        op("lb11",        1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0);
        op("lbu11",       1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h00000080, 1'b0);
        op("lw10_b",      1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0);
        op("lh12",        1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
        op("lhu12",       1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
        op("lh10",        1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFF80EF, 1'b0);
        op("lh13_err",    1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
        op("sw0c",        1'b1, 2'b10, 1'b0, 32'h0C, 32'h01020304, 32'h0, 1'b0);
        op("sw0e_err",    1'b1, 2'b10, 1'b0, 32'h0E, 32'hFFFFFFFF, 32'h0, 1'b1);
        op("lw0c",        1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'h01020304, 1'b0);
        op("sb0f",        1'b1, 2'b00, 1'b0, 32'h0F, 32'h00000077, 32'h0, 1'b0);
        op("lb0f",        1'b0, 2'b00, 1'b0, 32'h0F, 32'h0, 32'h00000077, 1'b0);
        op("sh0e",        1'b1, 2'b01, 1'b0, 32'h0E, 32'h1234BEEF, 32'h0, 1'b0);
        op("lw0c_b",      1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hBEEF0304, 1'b0);
        op("sw400_err",   1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, 32'h0, 1'b1);
        op("lw0",         1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        op("lw400_err",   1'b0, 2'b10, 1'b0, 32'h410, 32'h0, 32'h0, 1'b1);
        op("sz3_ld_err",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        op("sz3_st_err",  1'b1, 2'b11, 1'b0, 32'h10, 32'h55555555, 32'h0, 1'b1);
        op("lwu10",       1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0);

        // Back-pressure: response held for 5 cycles while a second request waits.
        drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        check("stall_accept", {31'h0, rsp_valid}, 32'h1);
        drive(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("stall_rsp_rdata", rsp_rdata, 32'hDEAD80EF);
            check("stall_req_ready", {31'h0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("retire_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("retire_req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("second_accept", {31'h0, rsp_valid}, 32'h1);
        check("second_rdata",  rsp_rdata, 32'h0);
        check("second_err",    {31'h0, rsp_err}, 32'h0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        op("lw20",        1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0);

        // Reset while a response is pending, with a store presented during reset.
        op("sw24",        1'b1, 2'b10, 1'b0, 32'h24, 32'hA5A5A5A5, 32'h0, 1'b0);
        drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        req_valid = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_valid", {31'h0, rsp_valid}, 32'h1);
        drive(1'b1, 2'b10, 1'b0, 32'h10, 32'h11111111);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("mid_rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
        @(posedge clk); #1;
        check("in_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        req_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        op("post_rst_lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0);
        op("post_rst_lw24", 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'hA5A5A5A5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_bus.md
DATA_MEM_BUS -- requirements
Module: data_mem_bus

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words (power of 2, >=4).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width (ADDR_W >= log2(DEPTH)+2).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  request can be accepted.
REQ-007 SHALL have port req_we  in  1  1=store, 0=load.
REQ-008 SHALL have port req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-009 SHALL have port req_unsigned  in  1  load extension: 1=zero-extend, 0=sign-extend.
REQ-010 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-011 SHALL have port req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port rsp_valid  out  1  response present.
REQ-013 SHALL have port rsp_ready  in  1  consumer accepts response.
REQ-014 SHALL have port rsp_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  out  1  access fault flag, qualified by rsp_valid.

Function
REQ-016 SHALL store DEPTH x 32-bit words, word index = req_addr[log2(DEPTH)+1:2]; at simulation start every word SHALL be 0.
REQ-017 SHALL accept a request on a posedge where req_valid && req_ready (handshake); it SHALL allow at most one outstanding request.
REQ-018 SHALL drive req_ready = !rsp_valid (combinational), so no request is accepted while a response is held.
REQ-019 SHALL assert rsp_valid on the posedge that accepts a request (1-cycle latency) and hold rsp_valid, rsp_rdata and rsp_err stable until a posedge with rsp_ready=1, which SHALL clear rsp_valid.
REQ-020 SHALL NOT accept a new request on the same edge that retires a response (req_ready=0 during that cycle); peak throughput is one access per 2 cycles.
REQ-021 SHALL flag an error (rsp_err=1, rsp_rdata=0, memory unchanged) when any of the following holds: req_size=11; half access with addr[0]=1; word access with addr[1:0]!=00; any req_addr bit above log2(DEPTH)+1 set (out of range).
REQ-022 SHALL write on acceptance of a legal store: byte -> lane addr[1:0] gets wdata[7:0]; half -> lanes {addr[1],1}:{addr[1],0} get wdata[15:0]; word -> all lanes; unselected lanes SHALL be unchanged.
REQ-023 SHALL capture on acceptance of a legal load: lane(s) selected as in REQ-022, shifted to bit 0, then zero- or sign-extended to 32 bits per req_unsigned; req_unsigned SHALL be ignored for word loads.
REQ-024 SHALL return rsp_rdata=0, rsp_err=0 for a legal store.
REQ-025 SHALL sample memory for a load before any write on the same edge (there is never a same-edge store due to REQ-017).
REQ-026 SHALL ignore req_* inputs when req_valid=0 or req_ready=0.

Reset
REQ-027 SHALL, while rst_n=0, force rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1, immediately (asynchronously).
REQ-028 SHALL NOT clear memory contents on reset; a store presented on an edge while rst_n=0 SHALL NOT write.
REQ-029 SHALL discard a pending response when reset asserts mid-transaction; after release the first posedge with req_valid=1 SHALL be accepted.

Verification
REQ-030 SHALL cover: word store 0xDEADBEEF @0x10, then word load @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid one edge after each acceptance.
REQ-031 SHALL cover: byte store 0x80 @0x11 over that word, then signed byte load @0x11 -> 0xFFFFFF80, unsigned -> 0x00000080, word load @0x10 -> 0xDEAD80EF.
REQ-032 SHALL cover: half load @0x12 signed -> 0xFFFFDEAD; half load @0x13 -> rsp_err=1, rsp_rdata=0; word store @0x0E -> rsp_err=1, word @0x0C unchanged.
REQ-033 SHALL cover: DEPTH=256, word store @0x400 (out of range) -> rsp_err=1, word 0 unchanged; req_size=11 -> rsp_err=1.
REQ-034 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, second req_valid not accepted until one cycle after rsp_ready=1.
REQ-035 SHALL cover: rst_n pulsed low while rsp_valid=1 -> rsp_valid=0 immediately, req_ready=1, memory word previously written still reads back after release.
